filter_buf_pp: RTL and testbench
================================

Name: filter_buf_pp

Overview:
- Parametrised, double-buffered (ping-pong) filter coefficient store for the convolution datapath.
- The loader writes a K×K filter one row per handshake. The compute side sees a complete filter as one flat word.
- While the compute side consumes one filter, the next filter can be loaded into the other bank. Filter loading overlaps with compute.
- Replaces the fixed 4×4 single-bank buffer. Adds handshakes, an internal row counter, flush, and two-filter occupancy tracking.

Parameters:
- K, 4, filter dimension: rows per filter and elements per row; K ≥ 2.
- DW, 8, element width in bits.
- ROW_W, K*DW, width of one row word. Derived; do not override.
- FLT_W, K*K*DW, width of one full filter word. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous clear of pointers and occupancy.
- wr_valid  in  1  loader presents a row on wr_data.
- wr_ready  out  1  buffer can accept a row.
- wr_data  in  ROW_W  one filter row; element 0 in the MSBs.
- rd_valid  out  1  a complete filter is available.
- rd_release  in  1  consumer is done with the current filter.
- re  in  1  read enable for rd_data.
- rd_data  out  FLT_W  current filter; row 0 element 0 in the MSBs, row-major.

Behaviour:
- Storage:
  - Two banks, each holding K×K elements of DW bits.
  - Element contents are not reset.
- State registers:
  - wb: write bank, 1 bit.
  - rb: read bank, 1 bit.
  - wrow: row counter, 0..K-1, width clog2(K).
  - cnt: number of complete filters held, 0..2.
- Reset (rst==0 at a clock edge), all outputs and state:
  - wb=0, rb=0, wrow=0, cnt=0.
  - Therefore wr_ready=1, rd_valid=0, rd_data=0.
- Reset and flush mid-load: a partially written filter is discarded, and wrow returns to 0.
- Write handshake, on wr_valid && wr_ready:
  - Element j of the row is wr_data[ROW_W-1-j*DW -: DW].
  - It is written to bank[wb][wrow][j].
  - wrow increments.
- Filter commit:
  - Occurs on the handshake with wrow==K-1.
  - wrow wraps to 0, wb toggles, cnt increments.
  - rd_valid rises on the next cycle: one cycle of latency from the last row's handshake.
- wr_ready:
  - wr_ready = (cnt != 2). Combinational from registered state.
  - No dependence on rd_release in the same cycle, so no combinational path from rd_release to wr_ready.
  - While cnt==2, wr_valid is ignored and no state changes.
- Read side:
  - rd_valid = (cnt != 0).
  - rd_data = (re && rd_valid) ? bank[rb] flattened : 0. The output is combinational from the registers.
  - Bit mapping: element (r,c) occupies rd_data[FLT_W-1-(r*K+c)*DW -: DW].
  - No tri-state; the output is driven low when disabled.
- Release:
  - On rd_release && rd_valid: rb toggles and cnt decrements.
  - rd_release while rd_valid==0 is ignored.
- Simultaneous commit and release in one cycle:
  - cnt is unchanged; both rb and wb toggle.
  - The data just released is unaffected by the write, because the write targets bank wb ≠ rb when cnt==1.
- Write into the bank being read:
  - Impossible by construction. Writes proceed only when cnt ≤ 1, so wb ≠ rb whenever rd_valid==1.
- Flush:
  - flush=1 at a clock edge sets wb=rb=wrow=cnt=0.
  - Any write handshake or release in that same cycle is discarded.
  - Bank contents are retained but unreachable.
- Priority: rst > flush > normal operation.
- Assertions (bench):
  - cnt never exceeds 2.
  - wrow never exceeds K-1.
  - wr_ready and rd_valid are never both 0 after reset.

Test Plan:
- Basic load (K=4, DW=8):
  - Stimulus: write rows 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F back-to-back; re=1.
  - Required: rd_valid=1 exactly one cycle after the 4th handshake; rd_data=0x000102030405060708090A0B0C0D0E0F.
- Ping-pong full:
  - Stimulus: load filter A (all 0x11) and filter B (all 0x22) without release.
  - Required: wr_ready=0 after B commits; a 9th write attempt leaves state unchanged; rd_data shows A.
  - Then: release once → rd_data=all 0x22 on the next cycle, and wr_ready=1.
- Simultaneous commit and release:
  - Stimulus: with cnt=1 (filter A held), issue the last row of filter B and rd_release in the same cycle.
  - Required: cnt stays 1; rd_data = B next cycle.
- Enable masking:
  - Stimulus: re=0 with a filter held.
  - Required: rd_data=0 while rd_valid=1; release with rd_valid=0 does not change cnt.
- Partial-load discard:
  - Stimulus: write 2 rows, then pulse flush; write 4 new rows (0xFFEEDDCC each).
  - Required: rd_data=0xFFEEDDCC repeated four times, with none of the rows written before flush.
- Reset mid-operation:
  - Stimulus: with cnt=2, drive rst=0 for one edge.
  - Required: rd_valid=0, wr_ready=1, rd_data=0; repeat the basic-load scenario with K=3, DW=16 and check the mapping.

Source files
------------

// File: rtl/filter_buf_pp.sv
// Ping-pong K x K filter coefficient store: rows are loaded one per handshake into
// the write bank while the compute side reads the other bank as one flat word.
module filter_buf_pp #(
    parameter int unsigned K     = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned ROW_W = K * DW,
    parameter int unsigned FLT_W = K * K * DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [ROW_W-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_release,
    input  logic             re,
    output logic [FLT_W-1:0] rd_data
);
    localparam int unsigned RW = $clog2(K);
    localparam logic [RW-1:0] LastRow = RW'(K - 1);

    logic          wb_q, wb_d;
    logic          rb_q, rb_d;
    logic [RW-1:0] wrow_q, wrow_d;
    logic [1:0]    cnt_q, cnt_d;

    // Row dimension ascends so that a whole bank flattens with row 0 in the MSBs.
    logic [1:0][0:K-1][ROW_W-1:0] bank_q, bank_d;

    logic wr_fire;
    logic commit;
    logic release_fire;

    assign wr_ready     = (cnt_q != 2'd2);
    assign rd_valid     = (cnt_q != 2'd0);
    assign wr_fire      = wr_valid && wr_ready;
    assign commit       = wr_fire && (wrow_q == LastRow);
    assign release_fire = rd_release && rd_valid;

    always_comb begin
        wb_d   = wb_q;
        rb_d   = rb_q;
        wrow_d = wrow_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wb_d   = 1'b0;
            rb_d   = 1'b0;
            wrow_d = '0;
            cnt_d  = 2'd0;
        end else begin
            if (wr_fire) begin
                wrow_d = commit ? '0 : wrow_q + RW'(1);
            end
            if (commit) begin
                wb_d = ~wb_q;
            end
            if (release_fire) begin
                rb_d = ~rb_q;
            end
            // Commit and release together leave the occupancy unchanged.
            case ({commit, release_fire})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_comb begin
        bank_d = bank_q;
        if (wr_fire && !flush) begin
            bank_d[wb_q][wrow_q] = wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (re && rd_valid) begin
            rd_data = bank_q[rb_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            wrow_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            wrow_q <= wrow_d;
            cnt_q  <= cnt_d;
        end
    end

    // Coefficient storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

endmodule

// File: tb/tb_filter_buf_pp.sv
// Self-checking bench for filter_buf_pp: directed scenarios plus randomized traffic
// compared against a queue-of-filters reference model.
`timescale 1ns/1ps
module tb_filter_buf_pp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // K=4, DW=8 instance
    logic         rst = 1'b0, flush = 1'b0, wr_valid = 1'b0, rd_release = 1'b0, re = 1'b0;
    logic [31:0]  wr_data = '0;
    logic         wr_ready, rd_valid;
    logic [127:0] rd_data;

    // K=3, DW=16 instance
    logic         rst3 = 1'b0, flush3 = 1'b0, wv3 = 1'b0, rel3 = 1'b0, re3 = 1'b0;
    logic [47:0]  wd3 = '0;
    logic         wrdy3, rv3;
    logic [143:0] rd3;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model: complete filters in arrival order, plus the row-assembly state.
    logic [127:0] mq[$];
    logic [127:0] part;
    int           prow = 0;

    filter_buf_pp #(.K(4), .DW(8)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_release (rd_release),
        .re         (re),
        .rd_data    (rd_data)
    );

    filter_buf_pp #(.K(3), .DW(16)) dut3 (
        .clk        (clk),
        .rst        (rst3),
        .flush      (flush3),
        .wr_valid   (wv3),
        .wr_ready   (wrdy3),
        .wr_data    (wd3),
        .rd_valid   (rv3),
        .rd_release (rel3),
        .re         (re3),
        .rd_data    (rd3)
    );

    always @(negedge clk) begin
        if (chk_en) begin
            if (dut4.cnt_q > 2'd2 || dut4.wrow_q > 2'd3 || (!wr_ready && !rd_valid)) begin
                $display("FAIL invariant: cnt=%0d wrow=%0d wr_ready=%b rd_valid=%b",
                         dut4.cnt_q, dut4.wrow_q, wr_ready, rd_valid);
                fails++;
            end
        end
    end

    task automatic model_update();
        bit acc;
        bit rel;
        if (!rst || flush) begin
            mq.delete();
            prow = 0;
        end else begin
            acc = (mq.size() < 2);
            rel = rd_release && (mq.size() > 0);
            if (wr_valid && acc) begin
                part = {part[95:0], wr_data};
                prow++;
            end
            if (rel) void'(mq.pop_front());
            if (prow == 4) begin
                mq.push_back(part);
                prow = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic write_row(input logic [31:0] row);
        wr_valid = 1'b1;
        wr_data  = row;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic load_filter(input logic [7:0] b);
        for (int i = 0; i < 4; i++) write_row({4{b}});
    endtask

    task automatic release_one();
        rd_release = 1'b1;
        step();
        rd_release = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; rst3 = 1'b0; re = 1'b1;
        step();
        rst = 1'b1; rst3 = 1'b1;
        chk_en = 1'b1;
        tests++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL reset_rd_valid: got %b want 0", rd_valid); fails++;
        end
        tests++;
        if (wr_ready !== 1'b1) begin
            $display("FAIL reset_wr_ready: got %b want 1", wr_ready); fails++;
        end
        tests++;
        if (rd_data !== 128'h0) begin
            $display("FAIL reset_rd_data: got %h want 0", rd_data); fails++;
        end
    endtask

    task automatic test_basic_load();
        re = 1'b1;
        write_row(32'h00010203);
        write_row(32'h04050607);
        write_row(32'h08090A0B);
        tests++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL basic_early_valid: got %b want 0", rd_valid); fails++;
        end
        write_row(32'h0C0D0E0F);
        tests++;
        if (rd_valid !== 1'b1) begin
            $display("FAIL basic_valid_latency: got %b want 1", rd_valid); fails++;
        end
        tests++;
        if (rd_data !== 128'h000102030405060708090A0B0C0D0E0F) begin
            $display("FAIL basic_rd_data: got %h want 000102030405060708090a0b0c0d0e0f",
                     rd_data);
            fails++;
        end
        release_one();
        tests++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL basic_release: got rd_valid %b want 0", rd_valid); fails++;
        end
    endtask

    task automatic test_pingpong_full();
        re = 1'b1;
        load_filter(8'h11);
        load_filter(8'h22);
        tests++;
        if (wr_ready !== 1'b0) begin
            $display("FAIL full_wr_ready: got %b want 0", wr_ready); fails++;
        end
        write_row(32'h33333333);
        tests++;
        if (wr_ready !== 1'b0 || rd_valid !== 1'b1) begin
            $display("FAIL full_ignored_write: got wr_ready %b rd_valid %b want 0 1",
                     wr_ready, rd_valid);
            fails++;
        end
        tests++;
        if (rd_data !== {16{8'h11}}) begin
            $display("FAIL full_rd_data_a: got %h want %h", rd_data, {16{8'h11}}); fails++;
        end
        release_one();
        tests++;
        if (rd_data !== {16{8'h22}}) begin
            $display("FAIL full_rd_data_b: got %h want %h", rd_data, {16{8'h22}}); fails++;
        end
        tests++;
        if (wr_ready !== 1'b1) begin
            $display("FAIL full_wr_ready_after_release: got %b want 1", wr_ready); fails++;
        end
        release_one();
    endtask

    task automatic test_simultaneous();
        re = 1'b1;
        load_filter(8'hA5);
        for (int i = 0; i < 3; i++) write_row({4{8'h5A}});
        wr_valid   = 1'b1;
        wr_data    = {4{8'h5A}};
        rd_release = 1'b1;
        step();
        wr_valid   = 1'b0;
        rd_release = 1'b0;
        tests++;
        if (rd_valid !== 1'b1 || wr_ready !== 1'b1) begin
            $display("FAIL simul_cnt: got rd_valid %b wr_ready %b want 1 1", rd_valid, wr_ready);
            fails++;
        end
        tests++;
        if (rd_data !== {16{8'h5A}}) begin
            $display("FAIL simul_rd_data: got %h want %h", rd_data, {16{8'h5A}}); fails++;
        end
        release_one();
        tests++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL simul_drain: got rd_valid %b want 0", rd_valid); fails++;
        end
    endtask

    task automatic test_enable_mask();
        load_filter(8'h77);
        re = 1'b0;
        #1;
        tests++;
        if (rd_data !== 128'h0 || rd_valid !== 1'b1) begin
            $display("FAIL mask_rd_data: got %h valid %b want 0 valid 1", rd_data, rd_valid);
            fails++;
        end
        re = 1'b1;
        release_one();
        release_one();
        tests++;
        if (rd_valid !== 1'b0 || wr_ready !== 1'b1) begin
            $display("FAIL mask_empty_release: got rd_valid %b wr_ready %b want 0 1",
                     rd_valid, wr_ready);
            fails++;
        end
        load_filter(8'h66);
        release_one();
        tests++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL mask_cnt_after_empty_release: got rd_valid %b want 0", rd_valid);
            fails++;
        end
    endtask

    task automatic test_flush_partial();
        re = 1'b1;
        write_row(32'h01020304);
        write_row(32'h05060708);
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) write_row(32'hFFEEDDCC);
        tests++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL flush_early_valid: got %b want 0", rd_valid); fails++;
        end
        write_row(32'hFFEEDDCC);
        tests++;
        if (rd_data !== {4{32'hFFEEDDCC}}) begin
            $display("FAIL flush_rd_data: got %h want %h", rd_data, {4{32'hFFEEDDCC}});
            fails++;
        end
        release_one();
    endtask

    task automatic test_reset_mid();
        re = 1'b1;
        load_filter(8'h44);
        load_filter(8'h55);
        rst = 1'b0;
        step();
        rst = 1'b1;
        tests++;
        if (rd_valid !== 1'b0 || wr_ready !== 1'b1 || rd_data !== 128'h0) begin
            $display("FAIL reset_mid: got rd_valid %b wr_ready %b rd_data %h want 0 1 0",
                     rd_valid, wr_ready, rd_data);
            fails++;
        end
    endtask

    task automatic test_k3_mapping();
        logic [47:0] rows [3];
        rows[0] = 48'h0000_0001_0002;
        rows[1] = 48'h0003_0004_0005;
        rows[2] = 48'h0006_0007_0008;
        re3  = 1'b1;
        rst3 = 1'b0;
        step();
        rst3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wv3 = 1'b1;
            wd3 = rows[i];
            step();
            wv3 = 1'b0;
            if (i == 1) begin
                tests++;
                if (rv3 !== 1'b0) begin
                    $display("FAIL k3_early_valid: got %b want 0", rv3); fails++;
                end
            end
        end
        tests++;
        if (rv3 !== 1'b1) begin
            $display("FAIL k3_valid_latency: got %b want 1", rv3); fails++;
        end
        tests++;
        if (rd3 !== 144'h0000_0001_0002_0003_0004_0005_0006_0007_0008) begin
            $display("FAIL k3_rd_data: got %h want 000000010002000300040005000600070008", rd3);
            fails++;
        end
        tests++;
        if (rd3[31:16] !== 16'h0007) begin
            $display("FAIL k3_elem_2_1: got %h want 0007", rd3[31:16]); fails++;
        end
    endtask

    task automatic test_random();
        logic [127:0] exp_rd;
        for (int n = 0; n < 400; n++) begin
            wr_valid   = 1'($urandom_range(0, 1));
            wr_data    = $urandom;
            rd_release = ($urandom_range(0, 3) == 0);
            re         = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 31) == 0);
            step();
            exp_rd = (re && mq.size() > 0) ? mq[0] : 128'h0;
            tests++;
            if (rd_valid !== (mq.size() != 0)) begin
                $display("FAIL rand_rd_valid[%0d]: got %b want %b", n, rd_valid, mq.size() != 0);
                fails++;
            end
            tests++;
            if (wr_ready !== (mq.size() != 2)) begin
                $display("FAIL rand_wr_ready[%0d]: got %b want %b", n, wr_ready, mq.size() != 2);
                fails++;
            end
            tests++;
            if (rd_data !== exp_rd) begin
                $display("FAIL rand_rd_data[%0d]: got %h want %h", n, rd_data, exp_rd);
                fails++;
            end
        end
        wr_valid = 1'b0; rd_release = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_pingpong_full();
        test_simultaneous();
        test_enable_mask();
        test_flush_partial();
        test_reset_mid();
        test_k3_mapping();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
